// File: rtl/timer_device.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload modes, and a maskable level interrupt.
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    logic        enable;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            enable  <= 1'b0;
            mode    <= '0;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // COUNT of 0 or 1 both terminate here, so PRESET=0 never wraps
                        count   <= '0;
                        pending <= 1'b1;
                        state   <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode == MODE_RELOAD) begin
                        pending <= 1'b0;
                        state   <= enable ? ST_LOAD : ST_IDLE;
                    end else begin
                        enable <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the FSM so a bus write overrides the one-shot
            // Enable clear and any pending update on the same edge.
            if (wr_ctrl) begin
                enable  <= din[0];
                mode    <= din[2:1];
                im      <= din[3];
                pending <= 1'b0;
            end
            if (wr_preset)
                preset <= din;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, im, mode, enable};
            ADDR_PRESET: dout = preset;
            ADDR_COUNT:  dout = count;
            default:     dout = '0;
        endcase
    end

    assign irq = pending & im;

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device with hand-computed expectations.
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int unsigned total;
    int unsigned passed;

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance n rising edges, then sit 1 time unit past the last edge.
    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-edge bus write; inputs change right after the previous edge.
    task automatic write(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic check_all_zero(input string tag);
        read({tag, "_ctrl"},   2'd0, 32'd0);
        read({tag, "_preset"}, 2'd1, 32'd0);
        read({tag, "_count"},  2'd2, 32'd0);
        read({tag, "_rsvd"},   2'd3, 32'd0);
        check_irq({tag, "_irq"}, 1'b0);
    endtask

    initial begin
        total  = 0;
        passed = 0;

        // Reset with a simultaneous PRESET write that must be ignored
        reset = 1'b1;
        we    = 1'b1;
        addr  = 2'd1;
        din   = 32'hDEAD_BEEF;
        cycles(2);
        reset = 1'b0;
        we    = 1'b0;
        check_all_zero("reset");

        // One-shot, PRESET=5, IM=1
        write(2'd1, 32'd5);
        read("preset_rd", 2'd1, 32'd5);
        write(2'd0, 32'h9);                   // edge T
        check_irq("os_irq_T", 1'b0);
        cycles(2);                            // T+2
        read("os_cnt_T2", 2'd2, 32'd5);
        for (int k = 4; k >= 1; k--) begin
            cycles(1);
            read($sformatf("os_cnt_%0d", k), 2'd2, 32'(k));
            check_irq($sformatf("os_irq_cnt%0d", k), 1'b0);
        end
        cycles(1);                            // T+7
        read("os_cnt_T7", 2'd2, 32'd0);
        check_irq("os_irq_T7", 1'b1);
        cycles(1);                            // T+8
        read("os_ctrl_T8", 2'd0, 32'h8);
        check_irq("os_irq_T8", 1'b1);
        cycles(3);
        check_irq("os_irq_held", 1'b1);
        read("os_cnt_held", 2'd2, 32'd0);
        write(2'd0, 32'h8);
        check_irq("os_irq_clr", 1'b0);

        // Auto-reload PRESET=3, PRESET=6 written mid-count of the second period
        write(2'd1, 32'd3);
        write(2'd0, 32'hB);                   // edge T
        for (int i = 1; i <= 19; i++) begin
            if (i == 8) begin
                write(2'd1, 32'd6);
                read("ar_cnt_after_pw", 2'd2, 32'd2);
            end else begin
                cycles(1);
            end
            check_irq($sformatf("ar_irq_T%0d", i), (i == 5 || i == 10 || i == 18));
        end
        write(2'd0, 32'h8);
        cycles(2);
        check_irq("ar_stop_irq", 1'b0);
        read("ar_stop_ctrl", 2'd0, 32'h8);

        // IM=0: COUNT expires but irq stays low
        write(2'd1, 32'd4);
        write(2'd0, 32'h1);                   // edge T
        cycles(6);                            // T+6
        read("nm_cnt_T6", 2'd2, 32'd0);
        check_irq("nm_irq_T6", 1'b0);
        cycles(1);
        read("nm_ctrl_T7", 2'd0, 32'h0);
        write(2'd0, 32'h8);
        check_irq("nm_irq_wr", 1'b0);
        cycles(1);
        check_irq("nm_irq_after", 1'b0);

        // Freeze mid-count, ignored COUNT/reserved writes, restart, reset mid-count
        write(2'd1, 32'd10);
        write(2'd0, 32'h1);                   // edge T
        cycles(9);                            // T+9: COUNT=3
        read("fz_cnt3", 2'd2, 32'd3);
        write(2'd0, 32'h0);                   // T+10: 3->2
        cycles(1);
        read("fz_cnt_frozen", 2'd2, 32'd2);
        cycles(2);
        read("fz_cnt_still", 2'd2, 32'd2);
        write(2'd2, 32'h0000_FFFF);
        read("fz_cnt_wr_ign", 2'd2, 32'd2);
        write(2'd3, 32'h1234_5678);
        read("fz_rsvd", 2'd3, 32'd0);
        read("fz_cnt_rsvd", 2'd2, 32'd2);
        write(2'd0, 32'h1);                   // restart edge
        cycles(2);
        read("rs_reload", 2'd2, 32'd10);
        cycles(2);
        read("rs_cnt8", 2'd2, 32'd8);
        reset = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        din   = 32'h9;
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        check_all_zero("mid_reset");
        cycles(3);
        read("mid_reset_idle", 2'd2, 32'd0);

        // PRESET=0 behaves as PRESET=1
        write(2'd0, 32'h9);                   // edge T, PRESET is 0
        cycles(2);
        check_irq("p0_irq_T2", 1'b0);
        cycles(1);
        check_irq("p0_irq_T3", 1'b1);
        read("p0_cnt_T3", 2'd2, 32'd0);
        cycles(1);
        read("p0_cnt_T4", 2'd2, 32'd0);
        write(2'd0, 32'h8);
        check_irq("p0_irq_clr", 1'b0);

        // CTRL write on the INT edge keeps the written Enable
        write(2'd1, 32'd1);
        write(2'd0, 32'h9);                   // edge T
        cycles(3);                            // T+3: INT
        check_irq("pr_irq_T3", 1'b1);
        write(2'd0, 32'h9);                   // T+4
        read("pr_ctrl_T4", 2'd0, 32'h9);
        check_irq("pr_irq_T4", 1'b0);
        cycles(3);                            // T+7
        check_irq("pr_irq_T7", 1'b1);
        write(2'd0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timer_device.md
TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 Parameters: none; register map and widths are fixed.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  2  word offset within the device window (memory-stage address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write strobe from the memory stage, already qualified by device select and exception/interrupt kill.
REQ-006 din  input  32  store data from the memory stage.
REQ-007 dout  output  32  read data returned to the memory stage load-data mux.
REQ-008 irq  output  1  interrupt request to the CP0 cause/pending logic.

Function
REQ-009 CTRL layout: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask); bits[31:4] read 0 and ignore writes.
REQ-010 PRESET is a 32-bit read/write register.
REQ-011 COUNT is 32-bit, read-only; writes to addr 2 and addr 3 are ignored.
REQ-012 dout is combinational from addr and current register values, zero latency: CTRL zero-extended, PRESET, COUNT, or 0 for addr 3.
REQ-013 Register writes take effect at the clock edge where we=1; the FSM sees the new value from the next cycle.
REQ-014 FSM states: IDLE, LOAD, CNT, INT, held in a 2-bit state register.
REQ-015 IDLE: Enable=1 -> LOAD; otherwise stay in IDLE; COUNT held.
REQ-016 LOAD: COUNT <= PRESET; -> CNT.
REQ-017 CNT, Enable=0: -> IDLE; COUNT frozen.
REQ-018 CNT, Enable=1 and COUNT>1: COUNT <= COUNT-1; stay in CNT.
REQ-019 CNT, Enable=1 and COUNT<=1: COUNT <= 0; pending <= 1; -> INT.
REQ-020 INT, Mode=00/10/11 (one-shot): Enable <= 0; -> IDLE; pending stays set until cleared.
REQ-021 INT, Mode=01 (auto-reload): -> LOAD when Enable=1, else -> IDLE; pending <= 0 on leaving INT, so the pulse lasts exactly one cycle.
REQ-022 irq = pending AND IM, registered-source only, no combinational path from din.
REQ-023 Any CTRL write clears pending in the same edge.
REQ-024 A CTRL write coinciding with the one-shot Enable clear in INT takes priority: the written Enable value is stored.
REQ-025 A PRESET write during CNT does not alter COUNT; it is used at the next LOAD.
REQ-026 Latency from the Enable-setting write edge to irq high is max(PRESET,1)+2 cycles.
REQ-027 Auto-reload period is max(PRESET,1)+2 cycles.
REQ-028 PRESET=0 behaves as PRESET=1, with no underflow or wrap.
REQ-029 Clearing Enable mid-count then setting it again restarts from LOAD (IDLE->LOAD); there is no resume.

Reset
REQ-030 When reset=1 at an edge: CTRL, PRESET, COUNT and pending are set to 0, state to IDLE, and irq is low from the next cycle.
REQ-031 Reset overrides a simultaneous we, including reset asserted mid-count or while in INT.
REQ-032 After reset, dout reads 0 at every addr.

Verification
REQ-033 Reset, then read addr 0/1/2/3 -> dout=0 for all; irq=0.
REQ-034 Write PRESET=5, then CTRL=0x9 (IM=1, mode 0, enable) at edge T -> COUNT=5 at T+2, 4,3,2,1 at T+3..T+6, 0 at T+7; irq=1 from T+7 and held; CTRL reads 0x8 after T+8; a write of CTRL=0x8 drops irq at the next edge.
REQ-035 PRESET=3, CTRL=0xB (auto-reload) -> irq one-cycle pulses every 5 cycles; a PRESET=6 write mid-count leaves the current period unchanged and the next period at 8 cycles.
REQ-036 PRESET=4, CTRL=0x1 (IM=0) -> COUNT reaches 0 but irq stays 0; a later CTRL=0x8 write clears pending and irq stays 0.
REQ-037 Counting with COUNT=3, write CTRL=0x0 -> COUNT frozen at its value one cycle later; a write to addr 2 of 0xFFFF leaves COUNT unchanged; reset asserted mid-count -> all registers 0, state IDLE.
